// File: rtl/serializer_arbiter_if.sv
// Bus bundle between the requesters/serializer side and serializer_arbiter.
//   modport master : environment side, drives req, req_data and ser_busy and
//                    observes the arbiter outputs.
//   modport slave  : arbiter side, samples req, req_data and ser_busy and
//                    drives gnt, done, ser_load, ser_data, active_id, idle
//                    and load_err.
// Signals:
//   req       [N_REQ]          per-requester level request
//   req_data  [N_REQ*P_WIDTH]  packed words, requester i at [i*P_WIDTH +: P_WIDTH]
//   gnt       [N_REQ]          one-hot pulse, requester word captured
//   done      [N_REQ]          one-hot pulse, serializer finished the word
//   ser_load                   load strobe to the serializer
//   ser_data  [P_WIDTH]        word presented to the serializer
//   ser_busy                   serializer busy flag
//   active_id [ID_W]           current owner, valid while idle is 0
//   idle                       high only while the arbiter is idle
//   load_err                   one-cycle pulse on a load timeout
interface serializer_arbiter_if #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned P_WIDTH = 24
);
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]         req;
    logic [N_REQ*P_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]         gnt;
    logic [N_REQ-1:0]         done;
    logic                     ser_load;
    logic [P_WIDTH-1:0]       ser_data;
    logic                     ser_busy;
    logic [ID_W-1:0]          active_id;
    logic                     idle;
    logic                     load_err;

    modport master (
        output req, req_data, ser_busy,
        input  gnt, done, ser_load, ser_data, active_id, idle, load_err
    );

    modport slave (
        input  req, req_data, ser_busy,
        output gnt, done, ser_load, ser_data, active_id, idle, load_err
    );
endinterface

// File: rtl/serializer_arbiter.sv
// Round-robin arbiter that feeds one parallel word at a time to a serializer.
// A granted word is captured into ser_data and offered with ser_load until the
// serializer raises ser_busy; when ser_busy falls again the owner gets a done
// pulse. A load that is never accepted within LOAD_TIMEOUT cycles is dropped
// with a load_err pulse. All outputs are registered.
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    serializer_arbiter_if slave modport (requests, serializer handshake,
//          grant/done/error indications)
module serializer_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned P_WIDTH      = 24,
    parameter int unsigned LOAD_TIMEOUT = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    serializer_arbiter_if.slave bus
);
    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [P_WIDTH-1:0] ser_data_q, ser_data_d;
    logic               ser_load_q, ser_load_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               idle_q, idle_d;
    logic               load_err_q, load_err_d;

    logic [P_WIDTH-1:0] words [N_REQ];
    logic               sel_found;
    logic [ID_W-1:0]    sel_id;
    int unsigned        idx;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign words[g] = bus.req_data[g*P_WIDTH +: P_WIDTH];
    end

    // First requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % N_REQ;
            if (!sel_found && bus.req[ID_W'(idx)]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        active_id_d = active_id_q;
        cnt_d       = cnt_q;
        ser_data_d  = ser_data_q;
        ser_load_d  = ser_load_q;
        gnt_d       = '0;
        done_d      = '0;
        load_err_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ser_load_d = 1'b0;
                // A busy serializer left over from an abandoned transfer
                // blocks new grants until it goes quiet.
                if (sel_found && !bus.ser_busy) begin
                    ser_data_d    = words[sel_id];
                    active_id_d   = sel_id;
                    gnt_d[sel_id] = 1'b1;
                    ser_load_d    = 1'b1;
                    cnt_d         = '0;
                    rr_ptr_d      = ID_W'((32'(sel_id) + 1) % N_REQ);
                    state_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.ser_busy) begin
                    ser_load_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_WAIT;
                end else if (cnt_q == CNT_W'(LOAD_TIMEOUT - 1)) begin
                    // This edge is the LOAD_TIMEOUT-th LOAD cycle.
                    ser_load_d = 1'b0;
                    load_err_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (!bus.ser_busy) begin
                    done_d[active_id_q] = 1'b1;
                    state_d             = S_IDLE;
                end
            end
            default: begin
                ser_load_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        idle_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            active_id_q <= '0;
            cnt_q       <= '0;
            ser_data_q  <= '0;
            ser_load_q  <= 1'b0;
            gnt_q       <= '0;
            done_q      <= '0;
            idle_q      <= 1'b1;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            active_id_q <= active_id_d;
            cnt_q       <= cnt_d;
            ser_data_q  <= ser_data_d;
            ser_load_q  <= ser_load_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            idle_q      <= idle_d;
            load_err_q  <= load_err_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.ser_load  = ser_load_q;
    assign bus.ser_data  = ser_data_q;
    assign bus.active_id = active_id_q;
    assign bus.idle      = idle_q;
    assign bus.load_err  = load_err_q;
endmodule

// File: doc/serializer_arbiter.md
SERIALIZER_ARBITER -- requirements
Module: serializer_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter P_WIDTH, default 24, meaning the parallel word width handed to the serializer.
REQ-003 The block SHALL have parameter LOAD_TIMEOUT, default 4, meaning the maximum cycles ser_load stays high without ser_busy rising.
REQ-004 The block SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 The block SHALL have port req  input  N_REQ  per-requester level request.
REQ-007 The block SHALL have port req_data  input  N_REQ*P_WIDTH  packed words; requester i at bits [i*P_WIDTH +: P_WIDTH].
REQ-008 The block SHALL have port gnt  output  N_REQ  one-hot, one-cycle pulse: the word of requester i was captured.
REQ-009 The block SHALL have port done  output  N_REQ  one-hot, one-cycle pulse: the serializer finished requester i's word.
REQ-010 The block SHALL have port ser_load  output  1  load strobe to the serializer.
REQ-011 The block SHALL have port ser_data  output  P_WIDTH  word presented to the serializer.
REQ-012 The block SHALL have port ser_busy  input  1  serializer busy flag.
REQ-013 The block SHALL have port active_id  output  max(1,$clog2(N_REQ))  index of the current owner; valid whenever idle is 0.
REQ-014 The block SHALL have port idle  output  1  high only in state IDLE.
REQ-015 The block SHALL have port load_err  output  1  one-cycle pulse on a load timeout.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The FSM SHALL have states IDLE, LOAD and WAIT.
REQ-018 IDLE with req != 0 at edge t: select the first set bit at or after rr_ptr (wrapping modulo N_REQ), capture its req_data into ser_data, set active_id, pulse gnt[i], raise ser_load and enter LOAD; gnt and ser_load are therefore first visible in cycle t+1.
REQ-019 IDLE with req == 0: remain in IDLE, ser_load=0, gnt=0.
REQ-020 LOAD: hold ser_load=1 and ser_data constant; ser_data SHALL change only on a grant.
REQ-021 LOAD with ser_busy=1 sampled: drop ser_load and enter WAIT.
REQ-022 LOAD timeout: a counter increments each LOAD cycle; if it reaches LOAD_TIMEOUT with ser_busy still 0, drop ser_load, pulse load_err, leave done low, and return to IDLE.
REQ-023 WAIT with ser_busy=0 sampled: pulse done[active_id] and return to IDLE.
REQ-024 The earliest next grant SHALL occur in the cycle after done is visible.
REQ-025 rr_ptr SHALL update to (i+1) mod N_REQ at each grant to requester i, including when the transfer later ends in a timeout.
REQ-026 A requester holding req after its gnt is a new request; it is served again only under the rotation of REQ-025.
REQ-027 Changes to req or req_data while not in IDLE SHALL have no effect on the transfer in progress.
REQ-028 gnt, done and load_err SHALL never be high in the same cycle.
REQ-029 No more than one gnt bit and no more than one done bit SHALL be high in any cycle.
REQ-030 ser_busy=1 seen while in IDLE SHALL be ignored; no grant is issued until ser_busy is 0.

Reset
REQ-031 When rst_n=0 is sampled, the block SHALL go to IDLE with rr_ptr=0, ser_load=0, ser_data=0, gnt=0, done=0, load_err=0, active_id=0, idle=1 and the timeout counter at 0.
REQ-032 A reset during LOAD or WAIT SHALL abandon the transfer with no done pulse.
REQ-033 The first grant after reset SHALL be possible in the cycle after rst_n is sampled 1.

Verification
REQ-034 Single requester: N_REQ=4, req=0001, req_data[0]=0xA1B2C3, ser_busy rises 1 cycle after ser_load and stays high for 3 cycles -> gnt=0001 and ser_load with ser_data=0xA1B2C3 in the same cycle, one done=0001 pulse, then idle=1.
REQ-035 Round-robin: req=1111 held for 4 transfers -> grant order 0,1,2,3, then 0 again on the 5th.
REQ-036 Skip and wrap: rr_ptr=3, req=0101 -> grant to 0, then 2.
REQ-037 Timeout: ser_busy tied to 0, req=0010 -> ser_load high for exactly 4 cycles, one load_err pulse, no done, return to IDLE; the next req=0011 is granted to requester 0 (rr_ptr=2 wraps to 0).
REQ-038 Reset mid-WAIT: rst_n=0 for 1 cycle while ser_busy=1 -> all outputs at reset values, no done pulse; req=1000 after reset is granted to requester 3.
REQ-039 Data stability: change req_data[1] during LOAD and WAIT -> ser_data holds the value captured at grant.
